// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet receive frame controller.
//   - FSM state encoding and end-of-frame error codes
//   - Preamble / SFD byte values
//   - Default frame-length limits (post-SFD byte counts, FCS included)
package eth_rx_pkg;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;

   localparam int unsigned DEF_MIN_LEN = 64;
   localparam int unsigned DEF_MAX_LEN = 1518;
   localparam int unsigned DEF_HDR_LEN = 14;

   // Width of the post-SFD byte index
   localparam int unsigned IDX_W = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_CHECK,
      ST_DROP
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK    = 2'd0,
      ERR_CRC   = 2'd1,
      ERR_RUNT  = 2'd2,
      ERR_GIANT = 2'd3
   } err_t;

endpackage

// File: rtl/eth_rx_sfd_detect.sv
// Preamble counter and SFD matcher.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   load_i         : a preamble start byte was accepted; count restarts at 1
//   active_i       : controller is in its preamble-hunting state
//   rx_dv_i        : byte valid
//   rx_byte_i      : received byte
//   sfd_hit_o      : SFD seen after at least one preamble byte (same cycle as the byte)
module eth_rx_sfd_detect
   import eth_rx_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       load_i,
   input  logic       active_i,
   input  logic       rx_dv_i,
   input  logic [7:0] rx_byte_i,
   output logic       sfd_hit_o
);

   logic [2:0] pre_cnt_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pre_cnt_q <= '0;
      end else if (load_i) begin
         pre_cnt_q <= 3'd1;
      end else if (active_i) begin
         // saturate at 7: longer preambles are tolerated without wrapping
         if (rx_dv_i && (rx_byte_i == PREAMBLE_BYTE) && (pre_cnt_q != 3'd7))
            pre_cnt_q <= pre_cnt_q + 3'd1;
      end else begin
         pre_cnt_q <= '0;
      end
   end

   assign sfd_hit_o = active_i && rx_dv_i && (rx_byte_i == SFD_BYTE) && (pre_cnt_q != '0);

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Ethernet receive frame controller: tracks preamble/SFD, sequences the CRC
// engine, classifies header and payload bytes and reports frame status.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_rx_dv        : byte valid, contiguous for a whole frame
//   i_rx_byte      : received byte
//   i_crc_ok       : CRC residue match, valid one cycle after the last o_crc_en
//   o_crc_clr      : one-cycle CRC clear after the SFD
//   o_crc_en       : CRC byte enable
//   o_hdr_en       : current byte is a MAC header byte
//   o_pay_en       : current byte is a payload/FCS byte
//   o_byte_idx     : post-SFD index of the current byte
//   o_frame_done   : one-cycle end-of-frame strobe
//   o_err_code     : 0 ok, 1 CRC, 2 runt, 3 giant; valid with o_frame_done
//   o_busy         : controller is not idle
// All outputs are registered and refer to the byte sampled on the previous edge.
module eth_rx_frame_ctrl
   import eth_rx_pkg::*;
#(
   parameter int unsigned MIN_LEN = DEF_MIN_LEN,
   parameter int unsigned MAX_LEN = DEF_MAX_LEN,
   parameter int unsigned HDR_LEN = DEF_HDR_LEN
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_rx_dv,
   input  logic [7:0]       i_rx_byte,
   input  logic             i_crc_ok,
   output logic             o_crc_clr,
   output logic             o_crc_en,
   output logic             o_hdr_en,
   output logic             o_pay_en,
   output logic [IDX_W-1:0] o_byte_idx,
   output logic             o_frame_done,
   output logic [1:0]       o_err_code,
   output logic             o_busy
);

   localparam logic [IDX_W-1:0] MIN_L = IDX_W'(MIN_LEN);
   localparam logic [IDX_W-1:0] MAX_L = IDX_W'(MAX_LEN);
   localparam logic [IDX_W-1:0] HDR_L = IDX_W'(HDR_LEN);

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] byte_idx_q;
   logic             crc_clr_q;
   logic             crc_en_q;
   logic             hdr_en_q;
   logic             pay_en_q;
   logic             done_q;
   err_t             err_q;
   logic             busy_q;

   logic pre_start;
   logic sfd_load;
   logic sfd_hit;

   assign pre_start = i_rx_dv && (i_rx_byte == PREAMBLE_BYTE);
   // CHECK also accepts a new preamble so back-to-back frames need no idle gap
   assign sfd_load  = pre_start && ((state_q == ST_IDLE) || (state_q == ST_CHECK));

   eth_rx_sfd_detect u_sfd (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .load_i    (sfd_load),
      .active_i  (state_q == ST_PREAMBLE),
      .rx_dv_i   (i_rx_dv),
      .rx_byte_i (i_rx_byte),
      .sfd_hit_o (sfd_hit)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         byte_idx_q <= '0;
         crc_clr_q  <= 1'b0;
         crc_en_q   <= 1'b0;
         hdr_en_q   <= 1'b0;
         pay_en_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= ERR_OK;
         busy_q     <= 1'b0;
      end else begin
         crc_clr_q <= 1'b0;
         crc_en_q  <= 1'b0;
         hdr_en_q  <= 1'b0;
         pay_en_q  <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pre_start) begin
                  state_q <= ST_PREAMBLE;
                  busy_q  <= 1'b1;
               end
            end
            ST_PREAMBLE: begin
               if (!i_rx_dv) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (sfd_hit) begin
                  state_q   <= ST_DATA;
                  crc_clr_q <= 1'b1;
                  idx_q     <= '0;
               end else if (i_rx_byte != PREAMBLE_BYTE) begin
                  state_q <= ST_DROP;
               end
            end
            ST_DATA: begin
               if (!i_rx_dv) begin
                  state_q <= ST_CHECK;
               end else if (idx_q == MAX_L) begin
                  // oversize byte is not fed to the CRC; frame reported now
                  state_q <= ST_DROP;
                  done_q  <= 1'b1;
                  err_q   <= ERR_GIANT;
               end else begin
                  crc_en_q   <= 1'b1;
                  byte_idx_q <= idx_q;
                  hdr_en_q   <= (idx_q < HDR_L);
                  pay_en_q   <= (idx_q >= HDR_L);
                  idx_q      <= idx_q + 1'b1;
               end
            end
            ST_CHECK: begin
               done_q <= 1'b1;
               if (idx_q < MIN_L)
                  err_q <= ERR_RUNT;
               else if (!i_crc_ok)
                  err_q <= ERR_CRC;
               else
                  err_q <= ERR_OK;
               if (pre_start) begin
                  state_q <= ST_PREAMBLE;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_DROP: begin
               if (!i_rx_dv) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_crc_clr    = crc_clr_q;
   assign o_crc_en     = crc_en_q;
   assign o_hdr_en     = hdr_en_q;
   assign o_pay_en     = pay_en_q;
   assign o_byte_idx   = byte_idx_q;
   assign o_frame_done = done_q;
   assign o_err_code   = err_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Self-checking bench for eth_rx_frame_ctrl. A negedge monitor tallies output
// pulses and protocol violations; each scenario compares the tallies against
// totals derived from the frame-length and error rules.
module tb_eth_rx_frame_ctrl;

   localparam int MIN = 64;
   localparam int MAX = 1518;
   localparam int HDR = 14;

   typedef struct packed {
      int         clr;
      int         en;
      int         hdr;
      int         pay;
      int         done;
      logic [1:0] err;
   } cnt_t;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_rx_dv;
   logic [7:0]  i_rx_byte;
   logic        i_crc_ok;
   logic        o_crc_clr;
   logic        o_crc_en;
   logic        o_hdr_en;
   logic        o_pay_en;
   logic [10:0] o_byte_idx;
   logic        o_frame_done;
   logic [1:0]  o_err_code;
   logic        o_busy;

   int   vectors     = 0;
   int   miscompares = 0;
   cnt_t mon;
   int   proto;
   int   exp_idx;
   logic prev_clr, prev_done;

   eth_rx_frame_ctrl #(.MIN_LEN(MIN), .MAX_LEN(MAX), .HDR_LEN(HDR)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_rx_dv      (i_rx_dv),
      .i_rx_byte    (i_rx_byte),
      .i_crc_ok     (i_crc_ok),
      .o_crc_clr    (o_crc_clr),
      .o_crc_en     (o_crc_en),
      .o_hdr_en     (o_hdr_en),
      .o_pay_en     (o_pay_en),
      .o_byte_idx   (o_byte_idx),
      .o_frame_done (o_frame_done),
      .o_err_code   (o_err_code),
      .o_busy       (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Output monitor
   always @(negedge i_clk) begin
      if (i_reset) begin
         prev_clr  = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (o_crc_clr) begin
            mon.clr = mon.clr + 1;
            exp_idx = 0;
         end
         if (o_crc_en && int'(o_byte_idx) != exp_idx) proto = proto + 1;
         if (o_hdr_en !== (o_crc_en && int'(o_byte_idx) < HDR)) proto = proto + 1;
         if (o_pay_en !== (o_crc_en && int'(o_byte_idx) >= HDR)) proto = proto + 1;
         if (o_crc_clr && (o_crc_en || o_hdr_en || o_pay_en)) proto = proto + 1;
         if (o_crc_clr && prev_clr) proto = proto + 1;
         if (o_frame_done && prev_done) proto = proto + 1;
         if (o_crc_en) begin
            mon.en  = mon.en + 1;
            exp_idx = exp_idx + 1;
         end
         if (o_hdr_en) mon.hdr = mon.hdr + 1;
         if (o_pay_en) mon.pay = mon.pay + 1;
         if (o_frame_done) begin
            mon.done = mon.done + 1;
            mon.err  = o_err_code;
         end
         prev_clr  = o_crc_clr;
         prev_done = o_frame_done;
      end
   end

   // Reference model: adds one frame's expected effect to running totals.
   function automatic cnt_t model_frame(input cnt_t acc, input logic [7:0] sfd,
                                        input int ndata, input bit crc);
      cnt_t r = acc;
      int   n;
      if (sfd != 8'hD5) return r;
      n      = (ndata > MAX) ? MAX : ndata;
      r.clr  = r.clr + 1;
      r.en   = r.en + n;
      r.hdr  = r.hdr + ((n < HDR) ? n : HDR);
      r.pay  = r.pay + ((n > HDR) ? n - HDR : 0);
      r.done = r.done + 1;
      if (ndata > MAX)      r.err = 2'd3;
      else if (ndata < MIN) r.err = 2'd2;
      else if (!crc)        r.err = 2'd1;
      else                  r.err = 2'd0;
      return r;
   endfunction

   function automatic string fmt(input cnt_t c);
      return $sformatf("clr=%0d en=%0d hdr=%0d pay=%0d done=%0d err=%0d",
                       c.clr, c.en, c.hdr, c.pay, c.done, c.err);
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge i_clk);
      i_rx_dv   = 1'b1;
      i_rx_byte = b;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         i_rx_dv   = 1'b0;
         i_rx_byte = 8'($urandom);
      end
   endtask

   task automatic send_frame(input int npre, input logic [7:0] sfd, input int ndata,
                             input bit crc, input int gap);
      for (int i = 0; i < npre; i++) send_byte(8'h55);
      send_byte(sfd);
      // CRC status for this frame applied after the previous frame's check cycle
      i_crc_ok = crc;
      for (int i = 0; i < ndata; i++) send_byte(8'($urandom));
      idle_n(gap);
   endtask

   task automatic clear_mon();
      @(posedge i_clk);
      mon   = '0;
      proto = 0;
   endtask

   task automatic settle();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [7:0] bad_sfd();
      logic [7:0] b;
      do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
      return b;
   endfunction

   task automatic test_reset();
      #1;
      vectors++;
      if ({o_crc_clr, o_crc_en, o_hdr_en, o_pay_en, o_frame_done, o_busy, o_err_code, o_byte_idx} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got clr=%b en=%b hdr=%b pay=%b done=%b busy=%b err=%0d idx=%0d, want all 0",
                  o_crc_clr, o_crc_en, o_hdr_en, o_pay_en, o_frame_done, o_busy, o_err_code, o_byte_idx);
      end
      repeat (3) @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   task automatic test_good_frame();
      cnt_t exp;
      clear_mon();
      exp = model_frame('0, 8'hD5, 64, 1'b1);
      send_frame(7, 8'hD5, 64, 1'b1, 4);
      settle();
      vectors++;
      if (mon !== exp) begin
         miscompares++;
         $display("FAIL good_frame: got %s, want %s", fmt(mon), fmt(exp));
      end
      vectors++;
      if (proto !== 0) begin
         miscompares++;
         $display("FAIL good_frame_proto: got %0d violations, want 0", proto);
      end
   endtask

   task automatic test_length_rules();
      int   lens [7] = '{60, 63, 64, 64, 0, 1518, 63};
      bit   crcs [7] = '{1, 1, 1, 0, 1, 1, 0};
      cnt_t exp;
      for (int k = 0; k < 7; k++) begin
         clear_mon();
         exp = model_frame('0, 8'hD5, lens[k], crcs[k]);
         send_frame(7, 8'hD5, lens[k], crcs[k], 4);
         settle();
         vectors++;
         if (mon !== exp) begin
            miscompares++;
            $display("FAIL length_%0d_crc%0d: got %s, want %s", lens[k], crcs[k], fmt(mon), fmt(exp));
         end
         vectors++;
         if (proto !== 0) begin
            miscompares++;
            $display("FAIL length_%0d_proto: got %0d violations, want 0", lens[k], proto);
         end
      end
   endtask

   task automatic test_bad_sfd();
      clear_mon();
      send_byte(8'h55);
      send_byte(8'h55);
      send_byte(8'h5D);
      for (int i = 0; i < 10; i++) send_byte(8'($urandom));
      #1;
      vectors++;
      if (o_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_sfd_busy_drop: got %b, want 1", o_busy);
      end
      idle_n(4);
      settle();
      vectors++;
      if (mon !== cnt_t'('0)) begin
         miscompares++;
         $display("FAIL bad_sfd_counts: got %s, want all 0", fmt(mon));
      end
      vectors++;
      if (o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL bad_sfd_idle: got busy=%b, want 0", o_busy);
      end
   endtask

   task automatic test_giant();
      cnt_t exp;
      clear_mon();
      exp = model_frame('0, 8'hD5, 1519, 1'b1);
      send_frame(7, 8'hD5, 1519, 1'b1, 4);
      settle();
      vectors++;
      if (mon !== exp) begin
         miscompares++;
         $display("FAIL giant: got %s, want %s", fmt(mon), fmt(exp));
      end
      vectors++;
      if (proto !== 0) begin
         miscompares++;
         $display("FAIL giant_proto: got %0d violations, want 0", proto);
      end
   endtask

   task automatic test_reset_midframe();
      cnt_t exp;
      clear_mon();
      for (int i = 0; i < 7; i++) send_byte(8'h55);
      send_byte(8'hD5);
      for (int i = 0; i < 30; i++) send_byte(8'($urandom));
      #2;
      i_reset   = 1'b1;
      i_rx_byte = 8'hD5;
      #1;
      vectors++;
      if ({o_crc_clr, o_crc_en, o_hdr_en, o_pay_en, o_frame_done, o_busy, o_err_code, o_byte_idx} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got en=%b hdr=%b pay=%b busy=%b idx=%0d, want all 0",
                  o_crc_en, o_hdr_en, o_pay_en, o_busy, o_byte_idx);
      end
      vectors++;
      if (mon.done !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_done: got %0d done strobes, want 0", mon.done);
      end
      repeat (2) @(negedge i_clk);
      mon       = '0;
      proto     = 0;
      i_reset   = 1'b0;
      // frame remnant after reset: must not be picked up without a fresh 0x55
      send_byte(8'hD5);
      for (int i = 0; i < 5; i++) send_byte(8'hAA);
      idle_n(4);
      settle();
      vectors++;
      if (mon !== cnt_t'('0) || o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_remnant: got %s busy=%b, want all 0", fmt(mon), o_busy);
      end
      clear_mon();
      exp = model_frame('0, 8'hD5, 64, 1'b1);
      send_frame(7, 8'hD5, 64, 1'b1, 4);
      settle();
      vectors++;
      if (mon !== exp) begin
         miscompares++;
         $display("FAIL reset_mid_next: got %s, want %s", fmt(mon), fmt(exp));
      end
   endtask

   task automatic test_back_to_back();
      cnt_t exp = '0;
      clear_mon();
      exp = model_frame(exp, 8'hD5, 20, 1'b1);
      exp = model_frame(exp, 8'hD5, 64, 1'b1);
      exp = model_frame(exp, 8'hD5, 70, 1'b0);
      send_frame(3, 8'hD5, 20, 1'b1, 1);
      send_frame(1, 8'hD5, 64, 1'b1, 1);
      send_frame(9, 8'hD5, 70, 1'b0, 4);
      settle();
      vectors++;
      if (mon !== exp) begin
         miscompares++;
         $display("FAIL back_to_back: got %s, want %s", fmt(mon), fmt(exp));
      end
      vectors++;
      if (proto !== 0) begin
         miscompares++;
         $display("FAIL back_to_back_proto: got %0d violations, want 0", proto);
      end
   endtask

   task automatic test_random();
      cnt_t       exp;
      int         r, nd, np, gap;
      bit         crc;
      logic [7:0] sfd;
      for (int b = 0; b < 6; b++) begin
         clear_mon();
         exp = '0;
         for (int f = 0; f < 4; f++) begin
            r   = int'($urandom_range(0, 9));
            np  = int'($urandom_range(1, 10));
            crc = 1'($urandom);
            sfd = (r == 9) ? bad_sfd() : 8'hD5;
            if (r <= 5)      nd = int'($urandom_range(0, 80));
            else if (r <= 7) nd = int'($urandom_range(MIN - 2, MIN + 1));
            else             nd = int'($urandom_range(MAX - 1, MAX + 2));
            gap = (f == 3) ? 4 : int'($urandom_range(1, 3));
            exp = model_frame(exp, sfd, nd, crc);
            send_frame(np, sfd, nd, crc, gap);
         end
         settle();
         vectors++;
         if (mon !== exp) begin
            miscompares++;
            $display("FAIL random_batch%0d: got %s, want %s", b, fmt(mon), fmt(exp));
         end
         vectors++;
         if (proto !== 0) begin
            miscompares++;
            $display("FAIL random_batch%0d_proto: got %0d violations, want 0", b, proto);
         end
      end
   endtask

   initial begin
      i_reset   = 1'b1;
      i_rx_dv   = 1'b0;
      i_rx_byte = 8'h00;
      i_crc_ok  = 1'b0;
      mon       = '0;
      proto     = 0;
      exp_idx   = 0;
      prev_clr  = 1'b0;
      prev_done = 1'b0;
      test_reset();
      idle_n(2);
      test_good_frame();
      test_length_rules();
      test_bad_sfd();
      test_giant();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/eth_rx_frame_ctrl.md
ETH_RX_FRAME_CTRL -- requirements
Module: eth_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum legal post-SFD byte count (incl. FCS).
REQ-002 SHALL have parameter MAX_LEN, default 1518, maximum legal post-SFD byte count (incl. FCS).
REQ-003 SHALL have parameter HDR_LEN, default 14, MAC header bytes (DA+SA+type).
REQ-004 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_rx_dv  input  1  byte valid, contiguous high for a whole frame.
REQ-007 SHALL have port i_rx_byte  input  8  received byte, qualified by i_rx_dv.
REQ-008 SHALL have port i_crc_ok  input  1  CRC engine residue-match flag, valid 1 cycle after last o_crc_en.
REQ-009 SHALL have port o_crc_clr  output  1  one-cycle CRC engine clear.
REQ-010 SHALL have port o_crc_en  output  1  CRC engine byte enable.
REQ-011 SHALL have port o_hdr_en  output  1  current byte is a header byte.
REQ-012 SHALL have port o_pay_en  output  1  current byte is payload/FCS byte.
REQ-013 SHALL have port o_byte_idx  output  11  post-SFD byte index of current byte.
REQ-014 SHALL have port o_frame_done  output  1  one-cycle end-of-frame strobe.
REQ-015 SHALL have port o_err_code  output  2  0 ok, 1 CRC, 2 runt, 3 giant; valid with o_frame_done.
REQ-016 SHALL have port o_busy  output  1  high in any state except IDLE.

Function
REQ-017 SHALL implement states IDLE, PREAMBLE, DATA, CHECK, DROP; all outputs registered.
REQ-018 IDLE: i_rx_dv & byte 0x55 -> PREAMBLE, preamble count=1; anything else stays IDLE.
REQ-019 PREAMBLE: 0x55 -> count+1, saturating at 7; 0xD5 with count>=1 -> DATA and o_crc_clr pulse next cycle; any other byte -> DROP; i_rx_dv low -> IDLE, no o_frame_done.
REQ-020 DATA: each valid byte drives o_crc_en=1, o_byte_idx=index (0 first after SFD), o_hdr_en=1 when index<HDR_LEN, else o_pay_en=1, in the cycle after the byte is sampled.
REQ-021 DATA: index counter 11-bit, increments per byte; byte with index==MAX_LEN (i.e. count MAX_LEN+1) -> DROP with o_frame_done and o_err_code=3 next cycle, no o_crc_en for that byte.
REQ-022 DATA: i_rx_dv low -> CHECK; CHECK lasts exactly one cycle, samples i_crc_ok.
REQ-023 CHECK: byte count<MIN_LEN -> err 2; else !i_crc_ok -> err 1; else err 0; o_frame_done pulses the following cycle; return to IDLE.
REQ-024 Runt SHALL take priority over CRC error.
REQ-025 DROP: ignore bytes, no enables; i_rx_dv low -> IDLE.
REQ-026 Byte 0x55 arriving in the cycle CHECK->IDLE SHALL be accepted as a new preamble start (zero IFG tolerance).
REQ-027 o_crc_clr, o_frame_done SHALL be single-cycle pulses; o_crc_en, o_hdr_en, o_pay_en never simultaneously with o_crc_clr.

Reset
REQ-028 i_reset SHALL force IDLE and zero all counters and outputs (o_err_code=0, o_busy=0) asynchronously, mid-frame included, with no o_frame_done emitted.
REQ-029 After reset release, a frame SHALL be accepted only from a fresh 0x55.

Structure
REQ-030 Shared package eth_rx_pkg SHALL hold state encodings, err codes, PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, default length constants.
REQ-031 One sub-module eth_rx_sfd_detect (preamble counter + SFD match, pulse out) SHALL be instantiated; remaining FSM in top.

Verification
REQ-032 7x0x55, 0xD5, 64 bytes, i_crc_ok=1 -> one o_crc_clr, 64 o_crc_en, 14 o_hdr_en, 50 o_pay_en, o_frame_done with err 0.
REQ-033 Same frame with 60 bytes, i_crc_ok=1 -> o_frame_done, err 2.
REQ-034 64-byte frame, i_crc_ok=0 -> err 1.
REQ-035 0x55,0x55,0x5D,... -> DROP, no o_crc_clr, no o_frame_done, IDLE after dv low.
REQ-036 1519 post-SFD bytes -> 1518 o_crc_en, o_frame_done err 3, no second done at dv low.
REQ-037 i_reset at byte 30 of a frame -> all outputs 0 immediately; next good frame reports err 0.
